// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector. The transition table is built at elaboration from a
// KMP-style longest-border search over PATTERN, so the runtime logic is a constant mux.
module seq_detect_param #(
  parameter int unsigned            PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b0111,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int unsigned            CNT_W       = 8,
  parameter int unsigned            ST_W        = $clog2(PATTERN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             partial,
  output logic [ST_W-1:0]  current_state,
  output logic [ST_W-1:0]  next_state
);

  if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
    $error("seq_detect_param: PATTERN_LEN must be in 2..16");
  end

  if (ST_W != $clog2(PATTERN_LEN + 1)) begin : g_bad_st_w
    $error("seq_detect_param: ST_W must not be overridden");
  end

  // Pattern left-aligned so the first received bit is always at bit 15.
  localparam logic [15:0]        PAT_MSB = 16'(PATTERN) << (16 - PATTERN_LEN);
  localparam logic [ST_W-1:0]    FULL    = ST_W'(PATTERN_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  // Longest l <= max_l such that the last l bits of s[0..n-1] equal the first l pattern bits.
  function automatic int suffix_match(input logic [15:0] s, input int n, input int max_l);
    int  best;
    logic ok;
    best = 0;
    for (int l = 1; l <= 16; l++) begin
      if (l <= max_l && l <= n) begin
        ok = 1'b1;
        for (int j = 0; j < 16; j++) begin
          if (j < l) begin
            if (s[4'(n - l + j)] != PAT_MSB[4'(15 - j)]) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Next prefix length after matching k bits and then receiving b.
  function automatic int calc_delta(input int k, input logic b);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < k) s[4'(i)] = PAT_MSB[4'(15 - i)];
    end
    s[4'(k)] = b;
    return suffix_match(s, k + 1, k + 1);
  endfunction

  // Longest proper border of the full pattern: where the search resumes after an overlap match.
  function automatic int calc_fail();
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(PATTERN_LEN)) s[4'(i)] = PAT_MSB[4'(15 - i)];
    end
    return suffix_match(s, int'(PATTERN_LEN), int'(PATTERN_LEN) - 1);
  endfunction

  localparam logic [ST_W-1:0] FAIL_N = ST_W'(calc_fail());

  logic [ST_W-1:0] delta_tbl [2**ST_W][2];

  for (genvar gk = 0; gk < 2**ST_W; gk++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      if (gk < PATTERN_LEN) begin : g_live
        assign delta_tbl[gk][gb] = ST_W'(calc_delta(gk, gb != 0));
      end else begin : g_pad
        assign delta_tbl[gk][gb] = '0;
      end
    end
  end

  logic [ST_W-1:0] t;
  logic            hit;

  always_comb begin
    t   = delta_tbl[current_state][in];
    hit = (t == FULL);
    if (clr) begin
      next_state = '0;
    end else if (in_valid) begin
      if (hit) next_state = OVERLAP ? FAIL_N : '0;
      else     next_state = t;
    end else begin
      next_state = current_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_state <= '0;
      match         <= 1'b0;
      match_cnt     <= '0;
    end else begin
      current_state <= next_state;
      if (clr) begin
        match     <= 1'b0;
        match_cnt <= '0;
      end else begin
        match <= in_valid & hit;
        if (in_valid && hit && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
      end
    end
  end

  assign partial = (current_state != '0);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: five parameterisations, expected responses queued per
// vector and checked by an independent monitor one cycle later.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] din, dvld, dclr;

  always #5 clk = ~clk;

  // 0: default, 1: 1011 overlap, 2: 1011 no overlap, 3: CNT_W=2, 4: 2'b11
  logic       m_def, m_ov, m_nov, m_sat, m_p2;
  logic       p_def, p_ov, p_nov, p_sat, p_p2;
  logic [7:0] cnt_def, cnt_ov, cnt_nov, cnt_p2;
  logic [1:0] cnt_sat;
  logic [2:0] st_def, st_ov, st_nov, st_sat, ns_def, ns_ov, ns_nov, ns_sat;
  logic [1:0] st_p2, ns_p2;

  seq_detect_param u_def (
    .clk(clk), .rst_n(rst_n), .in(din[0]), .in_valid(dvld[0]), .clr(dclr[0]),
    .match(m_def), .match_cnt(cnt_def), .partial(p_def),
    .current_state(st_def), .next_state(ns_def)
  );

  seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .rst_n(rst_n), .in(din[1]), .in_valid(dvld[1]), .clr(dclr[1]),
    .match(m_ov), .match_cnt(cnt_ov), .partial(p_ov),
    .current_state(st_ov), .next_state(ns_ov)
  );

  seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst_n(rst_n), .in(din[2]), .in_valid(dvld[2]), .clr(dclr[2]),
    .match(m_nov), .match_cnt(cnt_nov), .partial(p_nov),
    .current_state(st_nov), .next_state(ns_nov)
  );

  seq_detect_param #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in(din[3]), .in_valid(dvld[3]), .clr(dclr[3]),
    .match(m_sat), .match_cnt(cnt_sat), .partial(p_sat),
    .current_state(st_sat), .next_state(ns_sat)
  );

  seq_detect_param #(.PATTERN_LEN(2), .PATTERN(2'b11)) u_p2 (
    .clk(clk), .rst_n(rst_n), .in(din[4]), .in_valid(dvld[4]), .clr(dclr[4]),
    .match(m_p2), .match_cnt(cnt_p2), .partial(p_p2),
    .current_state(st_p2), .next_state(ns_p2)
  );

  typedef struct {
    int         id;
    int         tag;
    logic       m;
    logic [7:0] cnt;
    logic [3:0] st;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   tag  = 0;

  // {partial, match, cnt[7:0], st[3:0]}
  function automatic logic [13:0] dut_obs(input int id);
    case (id)
      0:       return {p_def, m_def, cnt_def, 1'b0, st_def};
      1:       return {p_ov, m_ov, cnt_ov, 1'b0, st_ov};
      2:       return {p_nov, m_nov, cnt_nov, 1'b0, st_nov};
      3:       return {p_sat, m_sat, 6'b0, cnt_sat, 1'b0, st_sat};
      default: return {p_p2, m_p2, cnt_p2, 2'b0, st_p2};
    endcase
  endfunction

  function automatic logic [3:0] dut_ns(input int id);
    case (id)
      0:       return {1'b0, ns_def};
      1:       return {1'b0, ns_ov};
      2:       return {1'b0, ns_nov};
      3:       return {1'b0, ns_sat};
      default: return {2'b0, ns_p2};
    endcase
  endfunction

  task automatic check(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s vec%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Apply one bit to DUT id for exactly one edge; queue the post-edge expectation.
  task automatic drive(input int id, input logic b, input logic v, input logic c,
                       input logic m, input int cnt, input int st);
    @(negedge clk);
    #1;
    din  = '0;
    dvld = '0;
    dclr = '0;
    din[id]  = b;
    dvld[id] = v;
    dclr[id] = c;
    #1;
    tag++;
    check("next_state", tag, 32'(dut_ns(id)), 32'(st));
    sb.push_back('{id, tag, m, 8'(cnt), 4'(st)});
    @(posedge clk);
    #1;
    dvld = '0;
    dclr = '0;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [13:0] obs;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        obs = dut_obs(e.id);
        check("match", e.tag, 32'(obs[12]), 32'(e.m));
        check("match_cnt", e.tag, 32'(obs[11:4]), 32'(e.cnt));
        check("state", e.tag, 32'(obs[3:0]), 32'(e.st));
        check("partial", e.tag, 32'(obs[13]), 32'(e.st != 0));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c, pc;
    rst_n = 1'b0;
    din   = '0;
    dvld  = '0;
    dclr  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 0, {31'b0, p_def, m_def, cnt_def, 1'b0, st_def}, 32'h0);
    rst_n = 1'b1;

    // Default pattern 0111, two non-overlapping occurrences
    drive(0, 0, 1, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0, 2);
    drive(0, 1, 1, 0, 0, 0, 3);
    drive(0, 1, 1, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 1, 1);
    drive(0, 1, 1, 0, 0, 1, 2);
    drive(0, 1, 1, 0, 0, 1, 3);
    drive(0, 1, 1, 0, 1, 2, 0);

    // Clear, then a valid-gap with toggling input must hold the prefix
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0, 2);
    drive(0, 1, 1, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 0, 0, 3);
    drive(0, 1, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 0, 0, 3);
    drive(0, 1, 1, 0, 1, 1, 0);

    // clr wins over a completing valid bit
    drive(0, 0, 1, 0, 0, 1, 1);
    drive(0, 1, 1, 0, 0, 1, 2);
    drive(0, 1, 1, 0, 0, 1, 3);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0, 2);
    drive(0, 1, 1, 0, 0, 0, 3);
    drive(0, 1, 1, 0, 1, 1, 0);

    // Asynchronous reset mid-prefix
    drive(0, 0, 1, 0, 0, 1, 1);
    drive(0, 1, 1, 0, 0, 1, 2);
    drive(0, 1, 1, 0, 0, 1, 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, {31'b0, p_def, m_def, cnt_def, 1'b0, st_def}, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0, 2);
    drive(0, 1, 1, 0, 0, 0, 3);
    drive(0, 1, 1, 0, 1, 1, 0);

    // Pattern 1011, stream 1,0,1,1,0,1,1 with and without overlap
    drive(1, 1, 1, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 0, 2);
    drive(1, 1, 1, 0, 0, 0, 3);
    drive(1, 1, 1, 0, 1, 1, 1);
    drive(1, 0, 1, 0, 0, 1, 2);
    drive(1, 1, 1, 0, 0, 1, 3);
    drive(1, 1, 1, 0, 1, 2, 1);

    drive(2, 1, 1, 0, 0, 0, 1);
    drive(2, 0, 1, 0, 0, 0, 2);
    drive(2, 1, 1, 0, 0, 0, 3);
    drive(2, 1, 1, 0, 1, 1, 0);
    drive(2, 0, 1, 0, 0, 1, 0);
    drive(2, 1, 1, 0, 0, 1, 1);
    drive(2, 1, 1, 0, 0, 1, 1);

    // 2-bit counter saturates at 3 over five matches
    for (int r = 0; r < 5; r++) begin
      pc = (r > 3) ? 3 : r;
      c  = (r + 1 > 3) ? 3 : r + 1;
      drive(3, 0, 1, 0, 0, pc, 1);
      drive(3, 1, 1, 0, 0, pc, 2);
      drive(3, 1, 1, 0, 0, pc, 3);
      drive(3, 1, 1, 0, 1, c, 0);
    end

    // Pattern 11: back-to-back overlapping matches
    drive(4, 1, 1, 0, 0, 0, 1);
    drive(4, 1, 1, 0, 1, 1, 1);
    drive(4, 1, 1, 0, 1, 2, 1);

    repeat (3) @(negedge clk);
    #1;
    check("sb_drain", 0, 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
